apb_spi_nor_ctrl: RTL

APB-slave to serial SPI NOR flash bridge; next-generation replacement for the byte-parallel flash controller. Each APB transfer becomes one SPI frame: command byte, big-endian flash address, then a parametrised number of data bytes on 1-bit MOSI/MISO in SPI mode 0. It adds an automatic write-enable frame, APB wait states via `p_ready`, and `p_slverr` for out-of-range addresses.

---
 rtl/apb_spi_nor_ctrl_pkg.sv | 32 +++
 rtl/apb_spi_nor_ctrl_if.sv | 32 +++
 rtl/apb_spi_nor_ctrl_spi_shift_engine.sv | 76 +++++++
 rtl/apb_spi_nor_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/apb_spi_nor_ctrl_pkg.sv
// Shared constants and types for the APB to SPI NOR bridge.
// Command bytes, FSM states and parameter sanity helpers.
package apb_spi_nor_pkg;

  localparam logic [7:0] CMD_PROG = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;

  // Longest frame: cmd + 4 addr + 4 data bytes.
  localparam int FRAME_MAX = 72;
  localparam int BITW      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_GAP,
    ST_XFER,
    ST_DONE
  } state_t;

  function automatic bit params_ok(
    input int ab,
    input int db,
    input int div
  );
    return (ab == 3 || ab == 4) &&
           (db >= 1 && db <= 4) &&
           (div >= 2) &&
           (div % 2 == 0);
  endfunction

endpackage

// File: rtl/apb_spi_nor_ctrl_if.sv
// APB slave port plus SPI pins of the NOR bridge.
// slave = bridge view, master = bus/flash side view.
interface apb_spi_nor_ctrl_if;

  logic [31:0] p_addr;
  logic        p_write;
  logic        p_sel_x;
  logic        p_enable;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        p_slverr;
  logic        s_clk;
  logic        s_css;
  logic        s_mosi;
  logic        s_miso;

  modport slave (
    input  p_addr, p_write, p_sel_x,
    input  p_enable, p_wdata, s_miso,
    output p_rdata, p_ready, p_slverr,
    output s_clk, s_css, s_mosi
  );

  modport master (
    output p_addr, p_write, p_sel_x,
    output p_enable, p_wdata, s_miso,
    input  p_rdata, p_ready, p_slverr,
    input  s_clk, s_css, s_mosi
  );

endinterface

// File: rtl/apb_spi_nor_ctrl_spi_shift_engine.sv
// SPI mode-0 shifter: divider, bit counter, MOSI/MISO shifting.
// Frame word arrives left-aligned; MOSI is always its top bit.
module spi_shift_engine
  import apb_spi_nor_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BITW-1:0]      nbits,
  input  logic [FRAME_MAX-1:0] load,
  input  logic                 miso,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          rx,
  output logic                 sclk,
  output logic                 css,
  output logic                 mosi
);

  localparam int DCW = $clog2(CLK_DIV);
  localparam logic [DCW-1:0] HALF =
    DCW'(CLK_DIV / 2 - 1);
  localparam logic [DCW-1:0] LAST =
    DCW'(CLK_DIV - 1);

  logic [DCW-1:0]       div;
  logic [BITW-1:0]      bitn;
  logic [FRAME_MAX-1:0] sr;

  assign mosi = sr[FRAME_MAX-1];
  assign done = busy && (div == LAST) &&
                (bitn == nbits - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      div  <= '0;
      bitn <= '0;
      sr   <= '0;
      rx   <= '0;
      sclk <= 1'b0;
      css  <= 1'b1;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        css  <= 1'b0;
        sclk <= 1'b0;
        div  <= '0;
        bitn <= '0;
        sr   <= load;
      end
    end else begin
      if (div == HALF) begin
        sclk <= 1'b1;
        rx   <= {rx[30:0], miso};
      end
      if (div == LAST) begin
        div  <= '0;
        sclk <= 1'b0;
        if (done) begin
          busy <= 1'b0;
          css  <= 1'b1;
          sr   <= '0;
        end else begin
          bitn <= bitn + 1'b1;
          sr   <= sr << 1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_spi_nor_ctrl.sv
// APB slave turning each access into one SPI NOR frame,
// with optional write-enable prologue and range error.
module apb_spi_nor_ctrl
  import apb_spi_nor_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 4,
  parameter int CLK_DIV    = 2,
  parameter bit AUTO_WREN  = 1
) (
  input logic                p_clk,
  input logic                p_reset_n,
  apb_spi_nor_ctrl_if.slave  bus
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int NBITS = 8 + AW + DW;
  localparam int GCW   = $clog2(CLK_DIV);

  localparam logic [31:0] AMASK =
    32'((64'd1 << AW) - 64'd1);
  localparam logic [31:0] DMASK =
    32'((64'd1 << DW) - 64'd1);
  localparam logic [GCW-1:0] GAP_LAST =
    GCW'(CLK_DIV - 2);

  if (!params_ok(ADDR_BYTES, DATA_BYTES, CLK_DIV))
  begin : g_bad_params
    $error("apb_spi_nor_ctrl: illegal parameters");
  end

  function automatic logic [FRAME_MAX-1:0] frame(
    input logic [7:0]  cmd,
    input logic [31:0] a,
    input logic [31:0] d
  );
    logic [FRAME_MAX-1:0] w;
    w = {cmd, 64'd0};
    w = w | (72'(a & AMASK) << (64 - AW));
    w = w | (72'(d & DMASK) << (64 - AW - DW));
    return w;
  endfunction

  state_t               state;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 write_q;
  logic                 err_q;
  logic [GCW-1:0]       gap;
  logic                 start;
  logic [BITW-1:0]      nbits;
  logic [FRAME_MAX-1:0] ld_word;
  logic [31:0]          rdata;
  logic                 ready;
  logic                 slverr;

  logic        eng_busy;
  logic        eng_done;
  logic [31:0] eng_rx;
  logic        eng_sclk;
  logic        eng_css;
  logic        eng_mosi;

  logic        accept;
  logic        range_err;
  logic [31:0] addr_hi;

  assign addr_hi   = bus.p_addr >> AW;
  assign range_err = addr_hi != 32'd0;
  assign accept    = (state == ST_IDLE) &&
                     bus.p_sel_x && bus.p_enable &&
                     !eng_busy;

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      gap     <= '0;
      start   <= 1'b0;
      nbits   <= '0;
      ld_word <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      slverr  <= 1'b0;
    end else begin
      start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          ready  <= 1'b0;
          slverr <= 1'b0;
          if (accept) begin
            addr_q  <= bus.p_addr;
            wdata_q <= bus.p_wdata;
            write_q <= bus.p_write;
            err_q   <= range_err;
            if (range_err) begin
              state <= ST_DONE;
            end else if (bus.p_write && AUTO_WREN) begin
              start   <= 1'b1;
              nbits   <= BITW'(8);
              ld_word <= {CMD_WREN, 64'd0};
              state   <= ST_WREN;
            end else begin
              start   <= 1'b1;
              nbits   <= BITW'(NBITS);
              ld_word <= frame(
                bus.p_write ? CMD_PROG : CMD_READ,
                bus.p_addr,
                bus.p_write ? bus.p_wdata : 32'd0);
              state   <= ST_XFER;
            end
          end
        end
        ST_WREN: begin
          if (eng_done) begin
            gap   <= '0;
            state <= ST_GAP;
          end
        end
        // Chip select stays high CLK_DIV cycles here.
        ST_GAP: begin
          if (gap == GAP_LAST) begin
            start   <= 1'b1;
            nbits   <= BITW'(NBITS);
            ld_word <= frame(CMD_PROG, addr_q, wdata_q);
            state   <= ST_XFER;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        ST_XFER: begin
          if (eng_done) begin
            ready  <= 1'b1;
            slverr <= 1'b0;
            if (!write_q) rdata <= eng_rx & DMASK;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready  <= err_q;
          slverr <= err_q;
          err_q  <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_eng (
    .clk   (p_clk),
    .rst_n (p_reset_n),
    .start (start),
    .nbits (nbits),
    .load  (ld_word),
    .miso  (bus.s_miso),
    .busy  (eng_busy),
    .done  (eng_done),
    .rx    (eng_rx),
    .sclk  (eng_sclk),
    .css   (eng_css),
    .mosi  (eng_mosi)
  );

  assign bus.p_rdata  = rdata;
  assign bus.p_ready  = ready;
  assign bus.p_slverr = slverr;
  assign bus.s_clk    = eng_sclk;
  assign bus.s_css    = eng_css;
  assign bus.s_mosi   = eng_mosi;

endmodule
